// File: rtl/rename_pkg.sv
// Shared sizing for the rename free list: register-file geometry, slot counts and pointer widths.
package rename_pkg;

    localparam int unsigned DEF_PHY_REGS       = 96;
    localparam int unsigned DEF_PHY_INDEX      = 7;
    localparam int unsigned DEF_ARCH_REGS      = 32;
    localparam int unsigned DEF_FL_SIZE        = DEF_PHY_REGS - DEF_ARCH_REGS;
    localparam int unsigned DEF_FL_INDEX       = 6;
    localparam int unsigned DEF_DISPATCH_WIDTH = 4;
    localparam int unsigned DEF_COMMIT_WIDTH   = 4;
    localparam int unsigned COMMIT_CNT_W       = 3;

    typedef logic [DEF_PHY_INDEX-1:0] phy_tag_t;

endpackage

// File: rtl/free_list_compact.sv
// Prefix counter: for each slot, how many valid slots sit below it, plus the total valid count.
module free_list_compact #(
    parameter int unsigned Width = 4,
    parameter int unsigned CntW  = 3
) (
    input  logic [Width-1:0]           valid_i,
    output logic [Width-1:0][CntW-1:0] offset_o,
    output logic [CntW-1:0]            total_o
);

    always_comb begin
        logic [CntW-1:0] acc;
        acc      = '0;
        offset_o = '0;
        for (int k = 0; k < Width; k++) begin
            offset_o[k] = acc;
            acc         = acc + CntW'(valid_i[k]);
        end
        total_o = acc;
    end

endmodule

// File: rtl/rename_free_list.sv
// Physical-tag free list: speculative head for rename, commit head for recovery, shared tail
// for tags returned at retire.
module rename_free_list
    import rename_pkg::*;
#(
    parameter int unsigned PHY_REGS       = DEF_PHY_REGS,
    parameter int unsigned PHY_INDEX      = DEF_PHY_INDEX,
    parameter int unsigned ARCH_REGS      = DEF_ARCH_REGS,
    parameter int unsigned FL_SIZE        = DEF_FL_SIZE,
    parameter int unsigned FL_INDEX       = DEF_FL_INDEX,
    parameter int unsigned DISPATCH_WIDTH = DEF_DISPATCH_WIDTH,
    parameter int unsigned COMMIT_WIDTH   = DEF_COMMIT_WIDTH
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DISPATCH_WIDTH-1:0] alloc_req_i,
    input  logic                      stall_i,
    output logic [PHY_INDEX-1:0]      free_tag0_o,
    output logic [PHY_INDEX-1:0]      free_tag1_o,
    output logic [PHY_INDEX-1:0]      free_tag2_o,
    output logic [PHY_INDEX-1:0]      free_tag3_o,
    output logic [DISPATCH_WIDTH-1:0] free_valid_o,
    output logic                      fl_empty_o,
    input  logic [COMMIT_WIDTH-1:0]   free_valid_i,
    input  logic [PHY_INDEX-1:0]      free_tag0_i,
    input  logic [PHY_INDEX-1:0]      free_tag1_i,
    input  logic [PHY_INDEX-1:0]      free_tag2_i,
    input  logic [PHY_INDEX-1:0]      free_tag3_i,
    input  logic [COMMIT_CNT_W-1:0]   commit_alloc_cnt_i,
    input  logic                      recover_i,
    output logic [FL_INDEX:0]         count_o,
    output logic                      overflow_err_o
);

    localparam int unsigned CntW   = FL_INDEX + 1;
    localparam int unsigned SumW   = CntW + 1;
    localparam int unsigned AllocW = $clog2(DISPATCH_WIDTH + 1);
    localparam int unsigned FreeW  = $clog2(COMMIT_WIDTH + 1);

    logic [PHY_INDEX-1:0] entry_q [FL_SIZE];
    logic [FL_INDEX-1:0]  head_q, head_d;
    logic [FL_INDEX-1:0]  chead_q, chead_d;
    logic [FL_INDEX-1:0]  tail_q, tail_d;
    logic [CntW-1:0]      count_q, count_d;
    logic [CntW-1:0]      ccount_q, ccount_d;
    logic                 ovf_q, ovf_d;

    logic [DISPATCH_WIDTH-1:0][AllocW-1:0] alloc_off;
    logic [AllocW-1:0]                     alloc_num;
    logic [COMMIT_WIDTH-1:0][FreeW-1:0]    free_off;
    logic [FreeW-1:0]                      free_num;

    logic [PHY_INDEX-1:0] tag_in  [COMMIT_WIDTH];
    logic [PHY_INDEX-1:0] tag_out [DISPATCH_WIDTH];
    logic [FL_INDEX-1:0]  wr_ptr  [COMMIT_WIDTH];
    logic                 fl_empty;
    logic                 alloc_fire;
    logic [AllocW-1:0]    nalloc;
    logic [SumW-1:0]      spec_raw, commit_plus, commit_raw;

    // Pointer add modulo FL_SIZE; inc never exceeds FL_SIZE so one subtraction suffices.
    function automatic logic [FL_INDEX-1:0] ptr_add(input logic [FL_INDEX-1:0] ptr,
                                                    input logic [CntW-1:0]     inc);
        logic [SumW-1:0] sum;
        sum = SumW'(ptr) + SumW'(inc);
        if (sum >= SumW'(FL_SIZE)) begin
            sum = sum - SumW'(FL_SIZE);
        end
        return sum[FL_INDEX-1:0];
    endfunction

    function automatic logic [CntW-1:0] sat(input logic [SumW-1:0] val);
        return (val > SumW'(FL_SIZE)) ? CntW'(FL_SIZE) : val[CntW-1:0];
    endfunction

    free_list_compact #(
        .Width (DISPATCH_WIDTH),
        .CntW  (AllocW)
    ) u_alloc_compact (
        .valid_i  (alloc_req_i),
        .offset_o (alloc_off),
        .total_o  (alloc_num)
    );

    free_list_compact #(
        .Width (COMMIT_WIDTH),
        .CntW  (FreeW)
    ) u_free_compact (
        .valid_i  (free_valid_i),
        .offset_o (free_off),
        .total_o  (free_num)
    );

    assign tag_in[0] = free_tag0_i;
    assign tag_in[1] = free_tag1_i;
    assign tag_in[2] = free_tag2_i;
    assign tag_in[3] = free_tag3_i;

    always_comb begin
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            tag_out[k] = entry_q[ptr_add(head_q, CntW'(alloc_off[k]))];
        end
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            wr_ptr[k] = ptr_add(tail_q, CntW'(free_off[k]));
        end
    end

    assign free_tag0_o = tag_out[0];
    assign free_tag1_o = tag_out[1];
    assign free_tag2_o = tag_out[2];
    assign free_tag3_o = tag_out[3];

    assign fl_empty     = CntW'(alloc_num) > count_q;
    assign fl_empty_o   = fl_empty;
    assign free_valid_o = fl_empty ? '0 : alloc_req_i;
    assign alloc_fire   = (|alloc_req_i) & ~fl_empty & ~stall_i & ~recover_i;
    assign nalloc       = alloc_fire ? alloc_num : '0;

    always_comb begin
        head_d      = head_q;
        count_d     = count_q;
        spec_raw    = SumW'(count_q) + SumW'(free_num) - SumW'(nalloc);
        commit_plus = SumW'(ccount_q) + SumW'(free_num);
        commit_raw  = (commit_plus < SumW'(commit_alloc_cnt_i)) ? '0
                    : commit_plus - SumW'(commit_alloc_cnt_i);
        tail_d      = ptr_add(tail_q, CntW'(free_num));
        chead_d     = ptr_add(chead_q, CntW'(commit_alloc_cnt_i));
        ccount_d    = sat(commit_raw);
        ovf_d       = ovf_q | (commit_raw > SumW'(FL_SIZE));
        if (recover_i) begin
            // Squash: rewind to where the commit side will be after this cycle.
            head_d  = chead_d;
            count_d = ccount_d;
        end else begin
            head_d  = ptr_add(head_q, CntW'(nalloc));
            count_d = sat(spec_raw);
            ovf_d   = ovf_d | (spec_raw > SumW'(FL_SIZE));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q   <= '0;
            chead_q  <= '0;
            tail_q   <= '0;
            count_q  <= CntW'(FL_SIZE);
            ccount_q <= CntW'(FL_SIZE);
            ovf_q    <= 1'b0;
        end else begin
            head_q   <= head_d;
            chead_q  <= chead_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            ccount_q <= ccount_d;
            ovf_q    <= ovf_d;
        end
    end

    // Returned tags become visible to the read side only from the next cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FL_SIZE; i++) begin
                entry_q[i] <= PHY_INDEX'((ARCH_REGS + i) % PHY_REGS);
            end
        end else begin
            for (int k = 0; k < COMMIT_WIDTH; k++) begin
                if (free_valid_i[k]) begin
                    entry_q[wr_ptr[k]] <= tag_in[k];
                end
            end
        end
    end

    assign count_o        = count_q;
    assign overflow_err_o = ovf_q;

endmodule

// File: doc/rename_free_list.md
RENAME_FREE_LIST -- requirements
Module: rename_free_list

Interface
REQ-001 Parameters SHALL be (name, default, meaning): PHY_REGS, 96, physical register count; PHY_INDEX, 7, physical tag width; ARCH_REGS, 32, architectural registers; FL_SIZE, 64, free-list capacity (PHY_REGS-ARCH_REGS); FL_INDEX, 6, pointer width; DISPATCH_WIDTH, 4, rename slots; COMMIT_WIDTH, 4, retire slots.
REQ-002 Ports SHALL be (name, direction, width, meaning): clk, in, 1, clock.
REQ-003 reset, in, 1, reset, synchronous, active-high.
REQ-004 alloc_req_i, in, DISPATCH_WIDTH, per-slot request for a new destination tag.
REQ-005 stall_i, in, 1, rename stalled by downstream; no allocation.
REQ-006 free_tag<k>_o, out, PHY_INDEX each (k=0..3), tag for slot k.
REQ-007 free_valid_o, out, DISPATCH_WIDTH, slot k tag valid.
REQ-008 fl_empty_o, out, 1, insufficient tags for the current request.
REQ-009 free_valid_i, in, COMMIT_WIDTH, retire slot returns a tag.
REQ-010 free_tag<k>_i, in, PHY_INDEX each (k=0..3), returned tag.
REQ-011 commit_alloc_cnt_i, in, 3, number of allocations retired this cycle (0..4).
REQ-012 recover_i, in, 1, squash all speculative allocations.
REQ-013 count_o, out, FL_INDEX+1, speculative free count; overflow_err_o, out, 1, sticky count-exceeds-capacity error.

Function
REQ-014 Storage SHALL be an FL_SIZE x PHY_INDEX circular array with spec head, commit head, tail; all pointers wrap modulo FL_SIZE.
REQ-015 Slot k SHALL receive entry[head + number of requesting slots below k]; outputs combinational from current state, zero latency.
REQ-016 fl_empty_o SHALL assert when popcount(alloc_req_i) > count_o; free_valid_o then 0.
REQ-017 Allocation fires when alloc_req_i!=0, !fl_empty_o, !stall_i, !recover_i; head and count SHALL decrease by popcount(alloc_req_i) at the next edge.
REQ-018 Valid returned tags SHALL be compacted in slot order and written at tail..tail+n-1; tail advances by n.
REQ-019 Tags written in cycle t SHALL NOT be allocatable before cycle t+1; next count = count - alloc + free.
REQ-020 commit_count tracks entries between commit head and tail: commit_count_next = commit_count - commit_alloc_cnt_i + free count; commit head advances by commit_alloc_cnt_i.
REQ-021 On recover_i: head <= commit head next, count <= commit_count_next; frees and commits of that cycle SHALL still apply; no allocation that cycle.
REQ-022 Simultaneous alloc and free of wrap-around span SHALL index correctly modulo FL_SIZE.
REQ-023 If count or commit_count would exceed FL_SIZE, overflow_err_o SHALL set and hold until reset; counts saturate at FL_SIZE.

Reset
REQ-024 On reset entry[i] SHALL be ARCH_REGS+i; head, commit head, tail = 0; count = commit_count = FL_SIZE; overflow_err_o = 0.
REQ-025 Reset mid-operation SHALL discard all pending allocations, frees and recovery in that cycle.
REQ-026 After reset free_valid_o SHALL follow alloc_req_i combinationally; free_tag0_o = ARCH_REGS.

Structure
REQ-027 PHY_REGS, ARCH_REGS, FL_SIZE, DISPATCH_WIDTH, COMMIT_WIDTH, widths SHALL live in shared package rename_pkg.
REQ-028 Prefix-count/compaction SHALL be sub-module free_list_compact, instantiated for both the allocate and free sides.

Verification
REQ-029 Reset, alloc_req_i=4'b1111 -> tags 32,33,34,35 valid; next cycle count_o=60.
REQ-030 alloc_req_i=4'b1010 after reset -> slot1=32, slot3=33, slots 0/2 invalid; count_o=62.
REQ-031 Drain to count 2, alloc_req_i=4'b0111 -> fl_empty_o=1, no pointer change; same-cycle free of 2 tags -> next cycle allocation succeeds.
REQ-032 Allocate 8, commit_alloc_cnt_i=3, recover_i -> head=3, count_o=61; next allocation returns tag 35.
REQ-033 Cycle head/tail past 63 with frees of tags 90..93 -> tag order preserved across wrap, count_o consistent.
REQ-034 Free 1 tag when count=64 -> overflow_err_o=1 sticky until reset.
